stg_3_ex: RTL and testbench

STG_3_EX -- requirements
Module: stg_3_ex

---
 rtl/stg_3_ex_pkg.sv | 54 +++++
 rtl/stg_3_ex_seq_multiplier.sv | 79 +++++++
 rtl/stg_3_ex.sv | 189 ++++++++++++++++++
 tb/tb_stg_3_ex.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/stg_3_ex_pkg.sv
// -----------------------------------------------------------------------------
// stg_3_ex_pkg
//
// Shared definitions for the execute stage (stg_3_ex) and its iterative
// multiplier (seq_multiplier):
//   VALUE_W     datapath width in bits
//   REG_ADDR_W  register address width
//   ALU_OP_W    opcode width
//   SHAMT_W     number of rs2 bits that form a shift amount
//   CNT_W       width of the multiply iteration counter
//   alu_op_t    ALU opcode encoding (codes above ALU_MUL are undefined)
//   me_reg_t    contents of the EX/ME pipeline register
//   me_bubble() the ME register value that represents "no instruction"
// -----------------------------------------------------------------------------
package stg_3_ex_pkg;

  localparam int VALUE_W    = 16;
  localparam int REG_ADDR_W = 5;
  localparam int ALU_OP_W   = 4;
  localparam int SHAMT_W    = $clog2(VALUE_W);
  localparam int CNT_W      = $clog2(VALUE_W);

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SLL = 4'd5,
    ALU_SRL = 4'd6,
    ALU_MUL = 4'd7
  } alu_op_t;

  typedef struct packed {
    logic [VALUE_W-1:0]    aluout;
    logic                  aluzero;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
    logic                  print_value;
  } me_reg_t;

  // A bubble never writes the register file and never prints; its result
  // field reads as zero, so the zero flag is set.
  function automatic me_reg_t me_bubble();
    me_reg_t b;
    b.aluout      = '0;
    b.aluzero     = 1'b1;
    b.rd          = '0;
    b.reg_write   = 1'b0;
    b.print_value = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/stg_3_ex_seq_multiplier.sv
// -----------------------------------------------------------------------------
// seq_multiplier
//
// Iterative shift-add multiplier producing the low VALUE_W bits of the
// unsigned product a*b. One multiplier bit is consumed per busy cycle, so an
// operation occupies exactly VALUE_W busy cycles after the start edge.
//
// Ports:
//   clock    rising-edge clock
//   reset    asynchronous, active-low; aborts any operation in flight
//   start    latch a/b, clear accumulator and counter, go busy (ignored
//            while already busy)
//   a, b     operands (multiplicand, multiplier), sampled on the start edge
//   busy     an operation is in progress
//   last     this busy cycle processes the final multiplier bit
//   product  accumulator plus the current partial product; equals the full
//            product during the cycle in which last is high
// -----------------------------------------------------------------------------
import stg_3_ex_pkg::*;

module seq_multiplier (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [VALUE_W-1:0] a,
  input  logic [VALUE_W-1:0] b,
  output logic               busy,
  output logic               last,
  output logic [VALUE_W-1:0] product
);

  logic               busy_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [VALUE_W-1:0] mcand_q;   // multiplicand, shifted left each iteration
  logic [VALUE_W-1:0] mplier_q;  // multiplier, shifted right each iteration
  logic [VALUE_W-1:0] acc_q;
  logic [VALUE_W-1:0] partial;

  // The current multiplier bit always sits in mplier_q[0]; mcand_q already
  // carries the matching weight, so the partial product needs no shifter.
  assign partial = mplier_q[0] ? mcand_q : '0;

  // Exposing acc + partial lets the caller take the product on the same edge
  // that consumes the last bit, saving a cycle of latency.
  assign product = acc_q + partial;
  assign busy    = busy_q;
  assign last    = busy_q && (cnt_q == CNT_W'(VALUE_W - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else if (start && !busy_q) begin
      busy_q   <= 1'b1;
      cnt_q    <= '0;
      mcand_q  <= a;
      mplier_q <= b;
      acc_q    <= '0;
    end else if (busy_q) begin
      acc_q    <= product;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      if (last) begin
        // Clearing instead of incrementing keeps the counter from wrapping
        // inside an operation.
        busy_q <= 1'b0;
        cnt_q  <= '0;
      end else begin
        cnt_q  <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/stg_3_ex.sv
// -----------------------------------------------------------------------------
// stg_3_ex
//
// Execute stage of the pipeline. Single-cycle ALU operations (ADD, SUB, AND,
// OR, XOR, SLL, SRL) are computed combinationally and registered into the ME
// stage register on the next rising edge. MUL is handed to seq_multiplier and
// stalls upstream for VALUE_W cycles; ME receives bubbles meanwhile and the
// product, with the destination/control bits captured at issue, on the
// (VALUE_W+1)th edge.
//
// Ports:
//   clock                 rising-edge clock
//   reset                 asynchronous, active-low
//   r_ex_valid            an instruction is present in EX
//   r_ex_aluop            ALU opcode (alu_op_t encoding)
//   r_ex_rs1val/rs2val    operand values
//   r_ex_rd               destination register
//   r_ex_RegWrite         register-file write enable, passed to ME
//   r_ex_PrintValue       print request, passed to ME
//   r_me_aluout           registered result
//   r_me_rd               registered destination register
//   r_me_aluzero          registered (result == 0)
//   r_me_RegWrite         registered write enable
//   r_me_PrintValue       registered print request
//   ex_stall              combinational; upstream holds r_ex_* while high
// -----------------------------------------------------------------------------
import stg_3_ex_pkg::*;

module stg_3_ex (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  r_ex_valid,
  input  logic [ALU_OP_W-1:0]   r_ex_aluop,
  input  logic [VALUE_W-1:0]    r_ex_rs1val,
  input  logic [VALUE_W-1:0]    r_ex_rs2val,
  input  logic [REG_ADDR_W-1:0] r_ex_rd,
  input  logic                  r_ex_RegWrite,
  input  logic                  r_ex_PrintValue,
  output logic [VALUE_W-1:0]    r_me_aluout,
  output logic [REG_ADDR_W-1:0] r_me_rd,
  output logic                  r_me_aluzero,
  output logic                  r_me_RegWrite,
  output logic                  r_me_PrintValue,
  output logic                  ex_stall
);

  localparam logic [0:0] ST_IDLE     = 1'b0;
  localparam logic [0:0] ST_MUL_BUSY = 1'b1;

  logic [0:0]            state_q, state_d;
  me_reg_t               me_q, me_d;

  // Destination and control bits of the MUL in flight; the r_ex_* inputs are
  // not trusted once the multiply has been accepted.
  logic [REG_ADDR_W-1:0] hold_rd_q;
  logic                  hold_rw_q;
  logic                  hold_pv_q;

  alu_op_t               op;
  logic                  op_defined;
  logic [VALUE_W-1:0]    alu_result;
  logic [SHAMT_W-1:0]    shamt;

  logic                  mul_start;
  logic                  mul_busy;
  logic                  mul_last;
  logic [VALUE_W-1:0]    mul_product;

  assign op         = alu_op_t'(r_ex_aluop);
  assign op_defined = (r_ex_aluop <= ALU_MUL);
  assign shamt      = r_ex_rs2val[SHAMT_W-1:0];

  // ---------------------------------------------------------------------------
  // Single-cycle ALU. MUL and undefined codes yield zero here; MUL results
  // come from the multiplier instead.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: a default before the case keeps every path assigned, so no latch
    // is inferred for codes the case does not list.
    alu_result = '0;
    case (op)
      ALU_ADD: alu_result = r_ex_rs1val + r_ex_rs2val;
      ALU_SUB: alu_result = r_ex_rs1val - r_ex_rs2val;
      ALU_AND: alu_result = r_ex_rs1val & r_ex_rs2val;
      ALU_OR:  alu_result = r_ex_rs1val | r_ex_rs2val;
      ALU_XOR: alu_result = r_ex_rs1val ^ r_ex_rs2val;
      ALU_SLL: alu_result = r_ex_rs1val << shamt;
      ALU_SRL: alu_result = r_ex_rs1val >> shamt;
      default: alu_result = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Iterative multiplier
  // ---------------------------------------------------------------------------
  assign mul_start = (state_q == ST_IDLE) && r_ex_valid && (op == ALU_MUL);

  seq_multiplier u_mul (
    .clock   (clock),
    .reset   (reset),
    .start   (mul_start),
    .a       (r_ex_rs1val),
    .b       (r_ex_rs2val),
    .busy    (mul_busy),
    .last    (mul_last),
    .product (mul_product)
  );

  // Stall on the issue cycle and on every busy cycle except the final one;
  // during the final cycle upstream may present the next instruction, which
  // is accepted on the same edge that retires the product. Gating with reset
  // keeps the stall low while reset is held, even if a MUL is presented.
  assign ex_stall = reset &&
                    (mul_start || ((state_q == ST_MUL_BUSY) && !mul_last));

  // ---------------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (mul_start) state_d = ST_MUL_BUSY;
      end
      ST_MUL_BUSY: begin
        // !mul_busy only guards against the two trackers ever disagreeing.
        if (mul_last || !mul_busy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // ME stage register next value
  // ---------------------------------------------------------------------------
  always_comb begin
    me_d = me_bubble();
    if (state_q == ST_MUL_BUSY) begin
      if (mul_last) begin
        me_d.aluout      = mul_product;
        me_d.aluzero     = (mul_product == '0);
        me_d.rd          = hold_rd_q;
        me_d.reg_write   = hold_rw_q;
        me_d.print_value = hold_pv_q;
      end
    end else if (r_ex_valid && !mul_start) begin
      me_d.rd          = r_ex_rd;
      me_d.print_value = r_ex_PrintValue;
      if (op_defined) begin
        me_d.aluout    = alu_result;
        me_d.aluzero   = (alu_result == '0);
        me_d.reg_write = r_ex_RegWrite;
      end else begin
        // Undefined opcode: zero result, and never write the register file.
        me_d.aluout    = '0;
        me_d.aluzero   = 1'b1;
        me_d.reg_write = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      me_q      <= me_bubble();
      hold_rd_q <= '0;
      hold_rw_q <= 1'b0;
      hold_pv_q <= 1'b0;
    end else begin
      state_q <= state_d;
      me_q    <= me_d;
      if (mul_start) begin
        hold_rd_q <= r_ex_rd;
        hold_rw_q <= r_ex_RegWrite;
        hold_pv_q <= r_ex_PrintValue;
      end
    end
  end

  assign r_me_aluout     = me_q.aluout;
  assign r_me_aluzero    = me_q.aluzero;
  assign r_me_rd         = me_q.rd;
  assign r_me_RegWrite   = me_q.reg_write;
  assign r_me_PrintValue = me_q.print_value;

endmodule

// File: tb/tb_stg_3_ex.sv
// -----------------------------------------------------------------------------
// tb_stg_3_ex
//
// Directed bench for stg_3_ex (VALUE_W = 16). Inputs are driven 1 ns after a
// rising edge; outputs are sampled 1 ns after the edge that should load them.
// -----------------------------------------------------------------------------
module tb_stg_3_ex;
  import stg_3_ex_pkg::*;

  logic                  clock = 1'b0;
  logic                  reset = 1'b0;
  logic                  r_ex_valid;
  logic [ALU_OP_W-1:0]   r_ex_aluop;
  logic [VALUE_W-1:0]    r_ex_rs1val;
  logic [VALUE_W-1:0]    r_ex_rs2val;
  logic [REG_ADDR_W-1:0] r_ex_rd;
  logic                  r_ex_RegWrite;
  logic                  r_ex_PrintValue;
  logic [VALUE_W-1:0]    r_me_aluout;
  logic [REG_ADDR_W-1:0] r_me_rd;
  logic                  r_me_aluzero;
  logic                  r_me_RegWrite;
  logic                  r_me_PrintValue;
  logic                  ex_stall;

  int tests = 0;
  int fails = 0;
  int stalls;
  int bad;

  always #5 clock = ~clock;

  stg_3_ex dut (
    .clock           (clock),
    .reset           (reset),
    .r_ex_valid      (r_ex_valid),
    .r_ex_aluop      (r_ex_aluop),
    .r_ex_rs1val     (r_ex_rs1val),
    .r_ex_rs2val     (r_ex_rs2val),
    .r_ex_rd         (r_ex_rd),
    .r_ex_RegWrite   (r_ex_RegWrite),
    .r_ex_PrintValue (r_ex_PrintValue),
    .r_me_aluout     (r_me_aluout),
    .r_me_rd         (r_me_rd),
    .r_me_aluzero    (r_me_aluzero),
    .r_me_RegWrite   (r_me_RegWrite),
    .r_me_PrintValue (r_me_PrintValue),
    .ex_stall        (ex_stall)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op,
                       input logic [15:0] a, input logic [15:0] b,
                       input logic [4:0] rd, input logic rw, input logic pv);
    r_ex_valid      = v;
    r_ex_aluop      = op;
    r_ex_rs1val     = a;
    r_ex_rs2val     = b;
    r_ex_rd         = rd;
    r_ex_RegWrite   = rw;
    r_ex_PrintValue = pv;
  endtask

  task automatic check_me(input string tag, input logic [15:0] out,
                          input logic z, input logic [4:0] rd,
                          input logic rw, input logic pv);
    check({tag, "_aluout"},  32'(r_me_aluout),     32'(out));
    check({tag, "_aluzero"}, 32'(r_me_aluzero),    32'(z));
    check({tag, "_rd"},      32'(r_me_rd),         32'(rd));
    check({tag, "_regwr"},   32'(r_me_RegWrite),   32'(rw));
    check({tag, "_print"},   32'(r_me_PrintValue), 32'(pv));
  endtask

  // One single-cycle op with RegWrite=1, PrintValue=0.
  task automatic alu_vec(input string tag, input logic [3:0] op,
                         input logic [15:0] a, input logic [15:0] b,
                         input logic [4:0] rd, input logic [15:0] exp);
    drive(1'b1, op, a, b, rd, 1'b1, 1'b0);
    #1;
    check({tag, "_stall"}, 32'(ex_stall), 32'd0);
    tick();
    check_me(tag, exp, exp == 16'h0, rd, 1'b1, 1'b0);
  endtask

  // Presents a MUL and clocks until ex_stall drops (bounded). Returns the
  // number of stalled cycles and the number of non-bubble ME values seen.
  // With scramble set, the r_ex_* inputs are trashed after the issue edge.
  task automatic run_mul(input logic [15:0] a, input logic [15:0] b,
                         input logic [4:0] rd, input logic rw, input logic pv,
                         input logic scramble,
                         output int n_stall, output int n_bad);
    n_stall = 0;
    n_bad   = 0;
    drive(1'b1, ALU_MUL, a, b, rd, rw, pv);
    for (int i = 0; i < 40; i++) begin
      #1;
      if (!ex_stall) break;
      n_stall++;
      tick();
      if (r_me_RegWrite !== 1'b0 || r_me_PrintValue !== 1'b0 ||
          r_me_aluout !== 16'h0 || r_me_aluzero !== 1'b1)
        n_bad++;
      if (scramble && i == 0)
        drive(1'b0, ALU_ADD, 16'hDEAD, 16'hBEEF, 5'd31, 1'b0, 1'b0);
    end
  endtask

  initial begin
    // Reset asserted with a MUL presented: stall must stay low.
    drive(1'b1, ALU_MUL, 16'h0003, 16'h0004, 5'd1, 1'b1, 1'b1);
    #12;
    check("rst_stall", 32'(ex_stall), 32'd0);
    check_me("rst", 16'h0, 1'b1, 5'd0, 1'b0, 1'b0);
    drive(1'b0, ALU_ADD, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);
    #5 reset = 1'b1;
    tick();

    // Single-cycle ALU ops.
    alu_vec("add_wrap", ALU_ADD, 16'hFFFF, 16'h0002, 5'd3, 16'h0001);
    alu_vec("sub_zero", ALU_SUB, 16'h0005, 16'h0005, 5'd4, 16'h0000);
    alu_vec("srl",      ALU_SRL, 16'h8000, 16'h0013, 5'd5, 16'h1000);
    alu_vec("and",      ALU_AND, 16'hF0F0, 16'hFF00, 5'd6, 16'hF000);
    alu_vec("or",       ALU_OR,  16'h00F0, 16'h0F00, 5'd7, 16'h0FF0);
    alu_vec("xor",      ALU_XOR, 16'hFFFF, 16'h00FF, 5'd8, 16'hFF00);
    alu_vec("sll15",    ALU_SLL, 16'h0001, 16'h000F, 5'd9, 16'h8000);
    alu_vec("sll16",    ALU_SLL, 16'h0001, 16'h0010, 5'd10, 16'h0001);

    // MUL 0x0123 * 0x0010, then an ADD straight behind it.
    run_mul(16'h0123, 16'h0010, 5'd5, 1'b1, 1'b0, 1'b0, stalls, bad);
    check("mul1_stalls", 32'(stalls), 32'd16);
    check("mul1_bubbles", 32'(bad), 32'd0);
    tick();
    check_me("mul1", 16'h1230, 1'b0, 5'd5, 1'b1, 1'b0);
    alu_vec("add_after_mul", ALU_ADD, 16'h0001, 16'h0002, 5'd6, 16'h0003);

    // MUL 0xFFFF * 0xFFFF with PrintValue, inputs trashed mid-operation.
    run_mul(16'hFFFF, 16'hFFFF, 5'd7, 1'b1, 1'b1, 1'b1, stalls, bad);
    check("mul2_stalls", 32'(stalls), 32'd16);
    check("mul2_bubbles", 32'(bad), 32'd0);
    tick();
    check_me("mul2", 16'h0001, 1'b0, 5'd7, 1'b1, 1'b1);
    drive(1'b0, ALU_ADD, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);
    tick();
    check_me("after_mul2", 16'h0, 1'b1, 5'd0, 1'b0, 1'b0);

    // Back-to-back MULs: zero product, then 2*3.
    run_mul(16'h0000, 16'h0005, 5'd11, 1'b1, 1'b0, 1'b0, stalls, bad);
    check("mul3_stalls", 32'(stalls), 32'd16);
    tick();
    check_me("mul3", 16'h0000, 1'b1, 5'd11, 1'b1, 1'b0);
    run_mul(16'h0002, 16'h0003, 5'd12, 1'b1, 1'b0, 1'b0, stalls, bad);
    check("mul4_stalls", 32'(stalls), 32'd16);
    check("mul4_bubbles", 32'(bad), 32'd0);
    tick();
    check_me("mul4", 16'h0006, 1'b0, 5'd12, 1'b1, 1'b0);

    // Reset at iteration 7 of a MUL aborts it.
    drive(1'b1, ALU_MUL, 16'h1111, 16'h2222, 5'd9, 1'b1, 1'b1);
    repeat (8) tick();
    check("pre_rst_stall", 32'(ex_stall), 32'd1);
    reset = 1'b0;
    #1;
    check("midrst_stall", 32'(ex_stall), 32'd0);
    check_me("midrst", 16'h0, 1'b1, 5'd0, 1'b0, 1'b0);
    drive(1'b0, ALU_ADD, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);
    tick();
    #2 reset = 1'b1;
    bad = 0;
    repeat (20) begin
      tick();
      if (r_me_RegWrite !== 1'b0 || r_me_aluout !== 16'h0) bad++;
    end
    check("no_result_after_rst", 32'(bad), 32'd0);
    alu_vec("add_after_rst", ALU_ADD, 16'h0001, 16'h0001, 5'd2, 16'h0002);

    // Bubble, then an undefined opcode.
    drive(1'b0, ALU_ADD, 16'h1234, 16'h4321, 5'd13, 1'b1, 1'b1);
    tick();
    check_me("bubble", 16'h0, 1'b1, 5'd0, 1'b0, 1'b0);
    drive(1'b1, 4'd9, 16'h0005, 16'h0006, 5'd2, 1'b1, 1'b1);
    #1;
    check("undef_stall", 32'(ex_stall), 32'd0);
    tick();
    check_me("undef", 16'h0, 1'b1, 5'd2, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
